// File: rtl/btn_irq_sequencer.sv
// btn_irq_sequencer: AXI4-Lite master that initialises btnINT, then services its interrupt
// by reading PENDING, clearing it (W1C) and streaming the button bits out.
`timescale 1ns/1ps
module btn_irq_sequencer #(
    parameter int          C_M_AXI_ADDR_WIDTH = 4,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_BTN_WIDTH        = 4,
    parameter logic [31:0] C_INIT_CTRL        = 32'h0000_0001,
    parameter logic [31:0] C_INIT_MASK        = 32'h0000_000F
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              irq_in,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    output logic [C_BTN_WIDTH-1:0]            evt_data,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic                              init_done,
    output logic                              busy,
    output logic                              err,
    output logic [7:0]                        spurious_cnt
);
    localparam logic [2:0] W_CTRL   = 3'd0;
    localparam logic [2:0] W_MASK   = 3'd1;
    localparam logic [2:0] IDLE     = 3'd2;
    localparam logic [2:0] RD_PEND  = 3'd3;
    localparam logic [2:0] CLR_PEND = 3'd4;
    localparam logic [2:0] PUSH     = 3'd5;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_CTRL = C_M_AXI_ADDR_WIDTH'(4'h0);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_MASK = C_M_AXI_ADDR_WIDTH'(4'h4);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] A_PEND = C_M_AXI_ADDR_WIDTH'(4'h8);

    logic [2:0]                    state_q, state_d;
    logic                          issued_q, issued_d;
    logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [C_BTN_WIDTH-1:0]        evt_data_q, evt_data_d;
    logic                          evt_valid_q, evt_valid_d, init_done_q, init_done_d, err_q, err_d;
    logic [7:0]                    spur_q, spur_d;
    logic                          irq_meta_q, irq_sync_q;
    logic                          aw_ok, w_ok, b_hs, r_hs, empty;

    // A channel counts as complete once its VALID is down or is being accepted this cycle
    assign aw_ok = !awvalid_q || M_AXI_AWREADY;
    assign w_ok  = !wvalid_q || M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID && bready_q;
    assign r_hs  = M_AXI_RVALID && rready_q;
    assign empty = ~|M_AXI_RDATA[C_BTN_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rdata_d     = rdata_q;
        evt_data_d  = evt_data_q;
        evt_valid_d = evt_valid_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        spur_d      = spur_q;
        case (state_q)
            W_CTRL, W_MASK, CLR_PEND: begin
                if (!issued_q) begin
                    issued_d  = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
                if (issued_q && !bready_q && aw_ok && w_ok) bready_d = 1'b1;
                if (b_hs) begin
                    issued_d    = 1'b0;
                    bready_d    = 1'b0;
                    err_d       = err_q | (|M_AXI_BRESP);
                    state_d     = state_q == W_CTRL ? W_MASK : state_q == W_MASK ? IDLE : PUSH;
                    init_done_d = init_done_q | (state_q == W_MASK);
                    evt_valid_d = state_q == CLR_PEND;
                    evt_data_d  = state_q == CLR_PEND ? rdata_q[C_BTN_WIDTH-1:0] : evt_data_q;
                end
            end
            IDLE: state_d = irq_sync_q ? RD_PEND : IDLE;
            RD_PEND: begin
                if (!issued_q) begin
                    issued_d  = 1'b1;
                    arvalid_d = 1'b1;
                end
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (r_hs) begin
                    issued_d = 1'b0;
                    rready_d = 1'b0;
                    rdata_d  = M_AXI_RDATA;
                    err_d    = err_q | (|M_AXI_RRESP);
                    state_d  = empty ? IDLE : CLR_PEND;
                    spur_d   = spur_q + 8'(empty && spur_q != 8'hFF);
                end
            end
            PUSH: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = W_CTRL;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= W_CTRL;
            issued_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rdata_q     <= '0;
            evt_data_q  <= '0;
            evt_valid_q <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            spur_q      <= '0;
            irq_meta_q  <= 1'b0;
            irq_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rdata_q     <= rdata_d;
            evt_data_q  <= evt_data_d;
            evt_valid_q <= evt_valid_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            spur_q      <= spur_d;
            irq_meta_q  <= irq_in;
            irq_sync_q  <= irq_meta_q;
        end
    end

    assign M_AXI_AWADDR  = state_q == W_CTRL ? A_CTRL : state_q == W_MASK ? A_MASK : A_PEND;
    assign M_AXI_WDATA   = state_q == W_CTRL ? C_M_AXI_DATA_WIDTH'(C_INIT_CTRL) :
                           state_q == W_MASK ? C_M_AXI_DATA_WIDTH'(C_INIT_MASK) : rdata_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_ARADDR  = A_PEND;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign evt_data      = evt_data_q;
    assign evt_valid     = evt_valid_q;
    assign init_done     = init_done_q;
    assign busy          = state_q != IDLE;
    assign err           = err_q;
    assign spurious_cnt  = spur_q;
endmodule

// File: tb/tb_btn_irq_sequencer.sv
// tb_btn_irq_sequencer: randomized bench with a btnINT slave model and a transaction-level
// reference (expected writes, events, spurious count, error flag).
`timescale 1ns/1ps
module tb_btn_irq_sequencer;
    logic        clk = 1'b0, rst;
    logic        irq_in;
    logic [3:0]  awaddr, araddr, evt_data, wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        evt_valid, evt_ready, init_done, busy, err;
    logic [7:0]  spurious_cnt;
    int          total = 0, bad = 0;

    logic [31:0] pend, inject, wd_l, wd;
    logic [3:0]  wa_l, wa;
    logic        force_irq, aw_got, w_got, aw_now, w_now;
    logic [1:0]  bresp_cfg, rresp_cfg;
    int          aw_dly, w_dly, ar_dly, aw_cnt, w_cnt, ar_cnt;
    int          viol = 0, aw_hi = 0, w_hi = 0;
    logic [35:0] wlog[$];
    logic [3:0]  evq[$];

    logic [35:0] exp_w[$];
    logic [3:0]  exp_e[$];
    int          widx = 0, eidx = 0, exp_spur = 0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    btn_irq_sequencer dut (
        .ACLK(clk), .ARESET(rst), .irq_in(irq_in),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .init_done(init_done), .busy(busy), .err(err), .spurious_cnt(spurious_cnt)
    );

    // btnINT slave: irq follows the unmasked low pending bits; a write lands once both AW and W are in
    assign irq_in  = |pend[3:0] | force_irq;
    assign awready = awvalid && !aw_got && aw_cnt >= aw_dly;
    assign wready  = wvalid && !w_got && w_cnt >= w_dly;
    assign arready = arvalid && !rvalid && ar_cnt >= ar_dly;
    assign aw_now  = aw_got || (awvalid && awready);
    assign w_now   = w_got || (wvalid && wready);
    assign wa      = aw_got ? wa_l : awaddr;
    assign wd      = w_got ? wd_l : wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0; aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; wa_l <= '0; wd_l <= '0;
            bresp <= '0; rresp <= '0; rdata <= '0;
        end else begin
            if (awvalid && awready) begin aw_got <= 1'b1; wa_l <= awaddr; end
            else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin w_got <= 1'b1; wd_l <= wdata; end
            else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
            if (aw_now && w_now && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
                wlog.push_back({wa, wd});
                pend   <= (wa == 4'h8 ? pend & ~wd : pend) | inject;
            end else pend <= pend | inject;
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            end
            if (arvalid && arready) begin rvalid <= 1'b1; rdata <= pend; rresp <= rresp_cfg; ar_cnt <= 0; end
            else if (arvalid && !rvalid) ar_cnt <= ar_cnt + 1;
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (evt_valid && evt_ready) evq.push_back(evt_data);
        if (bready && (awvalid || wvalid)) viol <= viol + 1;
        if (awvalid) aw_hi <= aw_hi + 1;
        if (wvalid) w_hi <= w_hi + 1;
    end

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // One interrupt service: value v lands in PENDING (v==0 forces a bare irq pulse)
    task automatic serve(input logic [31:0] v, input bit rnd);
        int n;
        if (v[3:0] != 4'h0) begin
            exp_w.push_back({4'h8, v});
            exp_e.push_back(v[3:0]);
        end else if (exp_spur < 255) exp_spur++;
        inject = v; force_irq = (v[3:0] == 4'h0);
        cyc(1);
        inject = '0; force_irq = 1'b0;
        n = 0;
        while (!busy && n < 10) begin cyc(1); n++; end
        chk("svc_start", 36'(n < 10), 36'd1);
        n = 0;
        while (busy && n < 500) begin
            evt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc(1); n++;
        end
        chk("svc_end", 36'(n < 500), 36'd1);
        evt_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        logic [35:0] e;
        logic [3:0]  ev;
        while (exp_w.size() > 0) begin
            e = exp_w.pop_front();
            chk({tag, "_wr"}, widx < wlog.size() ? wlog[widx] : 36'hF_FFFF_FFFF, e);
            widx++;
        end
        chk({tag, "_nwr"}, 36'(wlog.size()), 36'(widx));
        while (exp_e.size() > 0) begin
            ev = exp_e.pop_front();
            chk({tag, "_evt"}, eidx < evq.size() ? 36'(evq[eidx]) : 36'hF_FFFF_FFFF, 36'(ev));
            eidx++;
        end
        chk({tag, "_nevt"}, 36'(evq.size()), 36'(eidx));
        chk({tag, "_spur"}, 36'(spurious_cnt), 36'(exp_spur));
        chk({tag, "_err"}, 36'(err), 36'(exp_err));
    endtask

    initial begin
        int n, nw, a0, w0;
        logic stab;
        logic [31:0] v;
        rst = 1'b1; inject = '0; force_irq = 1'b0; evt_ready = 1'b1;
        aw_dly = 0; w_dly = 0; ar_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        #100;
        chk("rst_valids", 36'({awvalid, wvalid, bready, arvalid, rready}), 36'd0);
        chk("rst_outs", 36'({init_done, err, evt_valid, evt_data, spurious_cnt}), 36'd0);
        #100 rst = 1'b0;
        exp_w.push_back({4'h0, 32'h0000_0001});
        exp_w.push_back({4'h4, 32'h0000_000F});
        n = 0;
        while (!init_done && n < 8) begin cyc(1); n++; end
        chk("init_lat", 36'(init_done), 36'd1);
        chk("prot_strb", 36'({awprot, arprot, wstrb}), 36'h00F);
        cyc(2);
        drain("init");

        serve(32'h0000_0005, 1'b0);
        drain("basic");

        for (int i = 0; i < 20; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            v = $urandom;
            if (v[3:0] == 4'h0) v[0] = 1'b1;
            if ($urandom_range(0, 3) == 0) v = '0;
            serve(v, 1'b1);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        drain("rand");

        serve(32'h0, 1'b0);
        drain("spur1");
        repeat (300) serve(32'h0, 1'b0);
        drain("spur_sat");
        chk("spur_255", 36'(spurious_cnt), 36'd255);

        // Held-off consumer with a second interrupt arriving during PUSH
        evt_ready = 1'b0;
        exp_w.push_back({4'h8, 32'h3}); exp_e.push_back(4'h3);
        exp_w.push_back({4'h8, 32'hC}); exp_e.push_back(4'hC);
        inject = 32'h3; cyc(1); inject = '0;
        n = 0;
        while (!evt_valid && n < 50) begin cyc(1); n++; end
        chk("bp_valid", 36'(evt_valid), 36'd1);
        nw = wlog.size();
        inject = 32'hC; cyc(1); inject = '0;
        stab = 1'b1;
        repeat (50) begin
            cyc(1);
            if (!evt_valid || evt_data !== 4'h3) stab = 1'b0;
        end
        chk("bp_stable", 36'(stab), 36'd1);
        chk("bp_nosvc", 36'(wlog.size()), 36'(nw));
        evt_ready = 1'b1;
        n = 0;
        while ((evq.size() < eidx + 2 || busy) && n < 200) begin cyc(1); n++; end
        drain("bp");

        aw_dly = 3; bresp_cfg = 2'b10; exp_err = 1'b1;
        a0 = aw_hi; w0 = w_hi;
        serve(32'h6, 1'b0);
        chk("aw_hi", 36'(aw_hi - a0), 36'd4);
        chk("w_hi", 36'(w_hi - w0), 36'd1);
        aw_dly = 0; bresp_cfg = 2'b00;
        drain("slverr");
        serve(32'h2, 1'b0);
        drain("err_sticky");

        // Reset while the clear write is stalled on AWREADY
        aw_dly = 6;
        inject = 32'h9; cyc(1); inject = '0;
        n = 0;
        while (!(awvalid && awaddr == 4'h8) && n < 50) begin cyc(1); n++; end
        chk("clr_seen", 36'(awvalid), 36'd1);
        cyc(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_axi", 36'({awvalid, wvalid, bready}), 36'd0);
        chk("arst_state", 36'({busy, init_done, evt_valid, err, spurious_cnt}), 36'h800);
        exp_err = 1'b0; exp_spur = 0; aw_dly = 0;
        cyc(3);
        rst = 1'b0;
        widx = wlog.size(); eidx = evq.size();
        exp_w.push_back({4'h0, 32'h0000_0001});
        exp_w.push_back({4'h4, 32'h0000_000F});
        n = 0;
        while (!init_done && n < 8) begin cyc(1); n++; end
        chk("reinit_lat", 36'(init_done), 36'd1);
        cyc(2);
        drain("reinit");

        rresp_cfg = 2'b10; exp_err = 1'b1;
        serve(32'hA, 1'b0);
        rresp_cfg = 2'b00;
        drain("rresp");

        chk("bready_early", 36'(viol), 36'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btn_irq_sequencer.md
Name: btn_irq_sequencer

Overview:
AXI4-Lite master controller that configures and services the btnINT button-interrupt peripheral.
- After reset it writes the CTRL and MASK registers.
- On interrupt it reads PENDING, clears it with a write-1-to-clear (W1C), and hands the event bits to fabric logic on a valid/ready stream.
- Sits between the btnINT slave port and user logic, so no processor is needed to service button events.

Parameters:
C_M_AXI_ADDR_WIDTH, 4, address width; the btnINT map is 0x0 CTRL, 0x4 MASK, 0x8 PENDING (W1C), 0xC RAW.
C_M_AXI_DATA_WIDTH, 32, AXI4-Lite data width; fixed at 32.
C_BTN_WIDTH, 4, number of button bits used from PENDING[C_BTN_WIDTH-1:0].
C_INIT_CTRL, 32'h0000_0001, value written to CTRL at init (bit0 = enable).
C_INIT_MASK, 32'h0000_000F, value written to MASK at init.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
irq_in  in  1  level interrupt from btnINT; asynchronous to ACLK
M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  tied 3'b000
M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  write-address handshake
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  tied 4'hF
M_AXI_WVALID / M_AXI_WREADY  out/in  1  write-data handshake
M_AXI_BRESP  in  2  write response
M_AXI_BVALID / M_AXI_BREADY  in/out  1  write-response handshake
M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address
M_AXI_ARPROT  out  3  tied 3'b000
M_AXI_ARVALID / M_AXI_ARREADY  out/in  1  read-address handshake
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID / M_AXI_RREADY  in/out  1  read-data handshake
evt_data  out  C_BTN_WIDTH  pending button bits
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
init_done  out  1  configuration complete
busy  out  1  high in any state except IDLE
err  out  1  sticky; set on any BRESP or RRESP != OKAY
spurious_cnt  out  8  count of irq services that read PENDING == 0; saturates at 255

Behaviour:
- Reset (asynchronous):
  - All VALID and READY outputs 0.
  - init_done = 0, err = 0, spurious_cnt = 0, evt_valid = 0, evt_data = 0.
  - FSM returns to W_CTRL.
  - A transaction in flight is abandoned; the bench re-resets the slave alongside the master.
- irq_in passes through a 2-flop synchronizer; the FSM uses only the synchronized level.
- FSM states: W_CTRL -> W_MASK -> IDLE -> RD_PEND -> (CLR_PEND -> PUSH | IDLE).
- Write sequence (W_CTRL, W_MASK, CLR_PEND):
  - AWVALID and WVALID assert together on state entry, with address and data held stable.
  - Each VALID drops independently on the cycle after its READY is sampled high.
  - BREADY asserts once both AW and W have completed and stays high until BVALID.
  - The state advances on the BVALID && BREADY cycle.
  - Minimum write latency is 3 cycles with zero-wait slaves.
- Read sequence (RD_PEND):
  - ARVALID is held until ARREADY.
  - RREADY then asserts until RVALID.
  - RDATA is captured on the RVALID && RREADY cycle.
- W_CTRL writes C_INIT_CTRL to 0x0. W_MASK writes C_INIT_MASK to 0x4.
- On the W_MASK response, init_done rises and stays 1 until reset.
- IDLE: if synchronized irq == 1, go to RD_PEND at 0x8.
- After RD_PEND:
  - If captured[C_BTN_WIDTH-1:0] == 0: increment spurious_cnt (saturating) and return to IDLE with no clear write.
  - Otherwise go to CLR_PEND, which writes the captured full 32-bit value back to 0x8.
- PUSH:
  - evt_data = captured bits; evt_valid = 1, held until evt_ready.
  - Leave on the evt_valid && evt_ready cycle, dropping evt_valid the next cycle.
  - If evt_ready is already 1 on entry, the event transfers in one cycle.
- Backpressure: while in PUSH, new interrupts are not serviced. They stay latched in btnINT PENDING and are serviced after returning to IDLE. No events are lost.
- irq deasserting during RD_PEND or CLR_PEND does not abort the sequence.
- Error responses: set err, then continue the sequence normally. A read error still uses the returned RDATA.
- AXI outputs are never driven X. Addresses are constants per state.

Test Plan:
1. Reset for 200 ns, zero-wait slave -> writes 0x0 = 0x00000001, then 0x4 = 0x0000000F; init_done = 1 within 8 cycles of reset release.
2. Slave PENDING = 0x5, irq_in pulsed high -> read 0x8, write 0x00000005 to 0x8, evt_data = 4'h5 with evt_valid, accepted when evt_ready = 1.
3. irq_in high with PENDING = 0 -> no write issued, spurious_cnt 0 -> 1, FSM back in IDLE; 300 spurious services -> spurious_cnt = 255.
4. evt_ready held 0 for 50 cycles with a second irq arriving meanwhile -> evt_valid and evt_data stable throughout; after the release, a second service occurs and the second event is delivered.
5. Slave delays AWREADY 3 cycles and WREADY 0 cycles, then returns BRESP = SLVERR -> WVALID drops first, AWVALID drops later, BREADY waits for both; err = 1 and stays 1 until reset.
6. ARESET asserted mid-CLR_PEND with AWVALID high -> AWVALID, WVALID and BREADY are 0 asynchronously; after release the init writes repeat from W_CTRL.
